// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: issues one I-cache request at a time, buffers
// returned instructions with their PCs for decode, and drops stale responses on redirect.
//
// state      | meaning
// S_RUN      | no request outstanding; may issue when buffer has room
// S_WAIT     | one request accepted, response pending
// S_DISCARD  | one request outstanding whose response will be dropped
module fetch_ctrl #(
  parameter int              ADDR     = 32,
  parameter int              INST     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [ADDR-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            ic_req_valid,
  output logic [ADDR-1:0] ic_req_addr,
  input  logic            ic_req_ready,
  input  logic            ic_resp_valid,
  input  logic [INST-1:0] ic_resp_inst,
  input  logic            redirect_valid,
  input  logic [ADDR-1:0] redirect_addr,
  output logic            inst_valid,
  output logic [ADDR-1:0] inst_pc,
  output logic [INST-1:0] inst,
  input  logic            inst_ready
);

  localparam int              PW    = $clog2(DEPTH);
  localparam int              CW    = PW + 1;
  localparam logic [CW-1:0]   FULL  = CW'(DEPTH);
  localparam logic [ADDR-1:0] STEP  = ADDR'(INST / 8);

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_DISCARD} state_t;

  state_t          state;
  logic [ADDR-1:0] pc;
  logic [ADDR-1:0] req_pc;
  logic [ADDR-1:0] pc_mem   [DEPTH];
  logic [INST-1:0] inst_mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            accept;
  logic            push;
  logic            pop;

  // Requests only leave from S_RUN, so count already covers the reserved slot.
  assign ic_req_valid = (state == S_RUN) && (count < FULL) && !redirect_valid && !reset;
  assign ic_req_addr  = pc;
  assign inst_valid   = (count != '0) && !redirect_valid && !reset;
  assign inst_pc      = pc_mem[rd_ptr];
  assign inst         = inst_mem[rd_ptr];

  assign accept = ic_req_valid && ic_req_ready;
  assign push   = (state == S_WAIT) && ic_resp_valid && !redirect_valid && !reset;
  assign pop    = inst_valid && inst_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= req_pc;
      inst_mem[wr_ptr] <= ic_resp_inst;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_RUN;
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      pc     <= redirect_addr;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      unique case (state)
        S_WAIT, S_DISCARD: state <= ic_resp_valid ? S_RUN : S_DISCARD;
        default:           state <= S_RUN;
      endcase
    end else begin
      unique case (state)
        S_RUN: begin
          if (accept) begin
            pc     <= pc + STEP;
            req_pc <= pc;
            state  <= S_WAIT;
          end
        end
        S_WAIT, S_DISCARD: begin
          if (ic_resp_valid) state <= S_RUN;
        end
        default: state <= S_RUN;
      endcase
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus random traffic, checked each cycle
// against a queue-based model of the fetch stream and a simple I-cache model.
module tb_fetch_ctrl;
  localparam int          ADDR     = 32;
  localparam int          INST     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h100;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            ic_req_valid;
  logic [ADDR-1:0] ic_req_addr;
  logic            ic_req_ready = 1'b0;
  logic            ic_resp_valid = 1'b0;
  logic [INST-1:0] ic_resp_inst = '0;
  logic            redirect_valid = 1'b0;
  logic [ADDR-1:0] redirect_addr = '0;
  logic            inst_valid;
  logic [ADDR-1:0] inst_pc;
  logic [INST-1:0] inst;
  logic            inst_ready = 1'b0;

  fetch_ctrl #(.ADDR(ADDR), .INST(INST), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
    .ic_resp_valid(ic_resp_valid), .ic_resp_inst(ic_resp_inst),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .inst_valid(inst_valid), .inst_pc(inst_pc), .inst(inst), .inst_ready(inst_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // fetch-stream model: expected buffered PCs in order, next fetch PC, one outstanding slot
  logic [31:0] m_q[$];
  logic [31:0] m_pc = RESET_PC;
  logic [31:0] m_req = '0;
  bit          m_out = 0;
  bit          m_stale = 0;
  // I-cache model
  bit          c_pend = 0;
  int          c_cnt = 0;
  logic [31:0] c_addr = '0;
  int          lat_min = 1, lat_max = 1, p_ready = 100, p_iready = 100;
  logic [31:0] acc_log[$];
  logic [31:0] pop_log[$];

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit rst, input bit rdr, input logic [31:0] raddr);
    bit exp_rv, exp_iv, acc, pop, resp;
    reset          = rst;
    redirect_valid = rdr;
    redirect_addr  = raddr;
    resp           = c_pend && (c_cnt == 0);
    ic_resp_valid  = resp;
    ic_resp_inst   = resp ? inst_of(c_addr) : $urandom;
    ic_req_ready   = !c_pend && ($urandom_range(99) < p_ready);
    inst_ready     = ($urandom_range(99) < p_iready);
    #3;
    exp_rv = !rst && !m_out && (m_q.size() < DEPTH) && !rdr;
    exp_iv = !rst && (m_q.size() != 0) && !rdr;
    chk("req_valid", 64'(ic_req_valid), 64'(exp_rv));
    if (exp_rv) chk("req_addr", 64'(ic_req_addr), 64'(m_pc));
    chk("inst_valid", 64'(inst_valid), 64'(exp_iv));
    if (exp_iv) begin
      chk("inst_pc", 64'(inst_pc), 64'(m_q[0]));
      chk("inst", 64'(inst), 64'(inst_of(m_q[0])));
    end
    acc = exp_rv && ic_req_ready;
    pop = exp_iv && inst_ready;
    if (resp) c_pend = 0;
    else if (c_pend) c_cnt--;
    if (acc) begin
      c_pend = 1;
      c_cnt  = $urandom_range(lat_max, lat_min) - 1;
      c_addr = m_pc;
      acc_log.push_back(m_pc);
    end
    if (rst) begin
      m_q.delete(); m_pc = RESET_PC; m_out = 0; m_stale = 0;
    end else if (rdr) begin
      m_q.delete(); m_pc = raddr;
      if (m_out) begin
        if (resp) begin m_out = 0; m_stale = 0; end
        else m_stale = 1;
      end
    end else begin
      if (pop) begin pop_log.push_back(m_q[0]); void'(m_q.pop_front()); end
      if (resp && m_out) begin
        if (!m_stale) m_q.push_back(m_req);
        m_out = 0; m_stale = 0;
      end
      if (acc) begin m_out = 1; m_stale = 0; m_req = m_pc; m_pc = m_pc + 32'd4; end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    cycle(1, 0, '0);
    cycle(1, 0, '0);
    acc_log.delete();
    pop_log.delete();
  endtask

  initial begin
    // sequential fetch, 1-cycle cache, decode always ready
    lat_min = 1; lat_max = 1; p_ready = 100; p_iready = 100;
    do_reset();
    repeat (8) cycle(0, 0, '0);
    chk("t1_nreq", 64'(acc_log.size() >= 3), 64'd1);
    chk("t1_req0", 64'(acc_log[0]), 64'h100);
    chk("t1_req1", 64'(acc_log[1]), 64'h104);
    chk("t1_req2", 64'(acc_log[2]), 64'h108);
    chk("t1_pop0", 64'(pop_log[0]), 64'h100);
    chk("t1_pop2", 64'(pop_log[2]), 64'h108);

    // buffer fill stops requests; one pop releases exactly one more
    p_iready = 0;
    do_reset();
    repeat (20) cycle(0, 0, '0);
    chk("t2_fill", 64'(acc_log.size()), 64'd4);
    p_iready = 100;
    cycle(0, 0, '0);
    p_iready = 0;
    repeat (10) cycle(0, 0, '0);
    chk("t2_one_more", 64'(acc_log.size()), 64'd5);
    chk("t2_next_pc", 64'(acc_log[4]), 64'h110);

    // request held while cache not ready
    p_iready = 100; p_ready = 0;
    do_reset();
    repeat (5) cycle(0, 0, '0);
    chk("t3_no_accept", 64'(acc_log.size()), 64'd0);
    p_ready = 100;
    repeat (2) cycle(0, 0, '0);
    chk("t3_first", 64'(acc_log[0]), 64'h100);

    // redirect with 0x10C outstanding and two entries buffered
    lat_min = 3; lat_max = 3; p_iready = 0;
    do_reset();
    for (int i = 0; i < 40 && !(m_out && m_req == 32'h10C); i++) cycle(0, 0, '0);
    chk("t4_reached", 64'(m_out && m_req == 32'h10C), 64'd1);
    p_iready = 100;
    cycle(0, 0, '0);
    chk("t4_buffered", 64'(m_q.size()), 64'd2);
    cycle(0, 1, 32'h2000);
    acc_log.delete();
    repeat (5) cycle(0, 0, '0);
    chk("t4_target", 64'(acc_log[0]), 64'h2000);

    // redirect coinciding with response in WAIT
    lat_min = 2; lat_max = 2;
    do_reset();
    cycle(0, 0, '0);
    cycle(0, 0, '0);
    cycle(0, 1, 32'h3000);
    acc_log.delete();
    repeat (3) cycle(0, 0, '0);
    chk("t5_target", 64'(acc_log[0]), 64'h3000);

    // two redirects while discarding: last target wins
    lat_min = 3; lat_max = 3;
    do_reset();
    cycle(0, 0, '0);
    cycle(0, 1, 32'h4000);
    cycle(0, 1, 32'h5000);
    cycle(0, 0, '0);
    acc_log.delete();
    repeat (3) cycle(0, 0, '0);
    chk("t5_last_wins", 64'(acc_log[0]), 64'h5000);

    // PC wrap at top of address space
    lat_min = 1; lat_max = 1;
    do_reset();
    cycle(0, 1, 32'hFFFF_FFFC);
    acc_log.delete();
    repeat (4) cycle(0, 0, '0);
    chk("t6_top", 64'(acc_log[0]), 64'hFFFF_FFFC);
    chk("t6_wrap", 64'(acc_log[1]), 64'h0);

    // reset mid-WAIT, late response must be ignored
    lat_min = 3; lat_max = 3;
    do_reset();
    cycle(0, 0, '0);
    cycle(1, 0, '0);
    acc_log.delete();
    pop_log.delete();
    repeat (8) cycle(0, 0, '0);
    chk("t6_restart", 64'(acc_log[0]), 64'h100);
    chk("t6_pop", 64'(pop_log[0]), 64'h100);

    // random traffic
    lat_min = 1; lat_max = 4; p_ready = 70; p_iready = 60;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(199) == 0) cycle(1, 0, '0);
      else if ($urandom_range(14) == 0)
        cycle(0, 1, ($urandom_range(3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC));
      else cycle(0, 0, '0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
